// File: rtl/sub_seq.sv
// Multi-cycle subtractor: A - B computed CHUNK bits per clock with a registered
// ripple carry, producing NZCV flags and a start/busy/done handshake.
module sub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             Z,
   output logic             V,
   output logic             C,
   output logic             N
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int NSLOT  = 1 << CW;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_a, r_b, r_work, r_result;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_z, r_v, r_c, r_n;

   logic [CHUNK-1:0] w_a_ch [NSLOT];
   logic [CHUNK-1:0] w_b_ch [NSLOT];
   logic [CHUNK:0]   w_sum;
   logic [WIDTH-1:0] w_work_next;
   logic             w_accept, w_last;

   // Chunk views of the operands; slots past NCHUNK only exist so the counter indexes cleanly.
   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NCHUNK) begin : g_used
            assign w_a_ch[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_ch[gi] = r_b[gi*CHUNK +: CHUNK];
            assign w_work_next[gi*CHUNK +: CHUNK] =
               (r_cnt == CW'(gi)) ? w_sum[CHUNK-1:0] : r_work[gi*CHUNK +: CHUNK];
         end else begin : g_pad
            assign w_a_ch[gi] = '0;
            assign w_b_ch[gi] = '0;
         end
      end
   endgenerate

   assign w_sum    = {1'b0, w_a_ch[r_cnt]} + {1'b0, ~w_b_ch[r_cnt]} + {{CHUNK{1'b0}}, r_carry};
   assign w_last   = (r_state == RUN) && (r_cnt == CW'(NCHUNK - 1));
   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = start ? RUN : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_z      <= 1'b0;
         r_v      <= 1'b0;
         r_c      <= 1'b0;
         r_n      <= 1'b0;
      end else if (w_accept) begin
         r_a     <= minuend;
         r_b     <= subtrahend;
         r_carry <= 1'b1;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_work  <= w_work_next;
         r_carry <= w_sum[CHUNK];
         r_cnt   <= r_cnt + 1'b1;
         // Visible outputs change only once the whole word is known.
         if (w_last) begin
            r_result <= w_work_next;
            r_c      <= w_sum[CHUNK];
            r_z      <= (w_work_next == '0);
            r_n      <= w_work_next[WIDTH-1];
            r_v      <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                        (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
         end
      end
   end

   assign busy   = (r_state == RUN);
   assign done   = (r_state == DONE);
   assign result = r_result;
   assign Z      = r_z;
   assign V      = r_v;
   assign C      = r_c;
   assign N      = r_n;
endmodule

// File: tb/tb_sub_seq.sv
// Bench for sub_seq: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results, and a single-chunk instance.
module tb_sub_seq;
   localparam int W  = 32;
   localparam int CH = 8;
   localparam int NC = W / CH;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          busy, done, z, v, c, n;
   logic [W-1:0]  result;

   logic          start2 = 1'b0;
   logic [W-1:0]  a2 = '0, b2 = '0;
   logic          busy2, done2, z2, v2, c2, n2;
   logic [W-1:0]  result2;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   sub_seq #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk(clk), .reset(reset), .start(start), .minuend(a), .subtrahend(b),
      .busy(busy), .done(done), .result(result), .Z(z), .V(v), .C(c), .N(n)
   );

   sub_seq #(.WIDTH(W), .CHUNK(W)) dut32 (
      .clk(clk), .reset(reset), .start(start2), .minuend(a2), .subtrahend(b2),
      .busy(busy2), .done(done2), .result(result2), .Z(z2), .V(v2), .C(c2), .N(n2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer subtraction; flags packed as {N,Z,C,V}
   function automatic logic [35:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      longint       sd;
      logic         nn, zz, cc, vv;
      r  = x - y;
      sd = longint'($signed(x)) - longint'($signed(y));
      nn = r[W-1];
      zz = (r == 0);
      cc = (x >= y);
      vv = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return {nn, zz, cc, vv, r};
   endfunction

   // Model: an operation takes NC edges after acceptance, then a one-cycle done.
   int           m_rem;
   logic         m_done;
   logic [W-1:0] m_res;
   logic [3:0]   m_fl;
   logic [35:0]  m_pend;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem  = 0;
         m_done = 1'b0;
         m_res  = '0;
         m_fl   = '0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1'b1;
            m_res  = m_pend[31:0];
            m_fl   = m_pend[35:32];
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_rem  = NC;
            m_pend = ref_sub(a, b);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy",   busy, (m_rem > 0));
         check("model_done",   done, m_done);
         check("model_result", result, m_res);
         check("model_flags",  {n, z, c, v}, m_fl);
      end
   end

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic [3:0] ef, input bit poke);
      int cyc;
      @(negedge clk);
      start = 1'b1; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      check("busy_after_accept", busy, 1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (poke && cyc == 2) begin
            start = 1'b1; a = $urandom; b = $urandom;
         end
         if (cyc == 3) start = 1'b0;
      end while (!done && cyc < 10);
      $display("op %08h - %08h -> %08h NZCV=%04b after %0d cycles", x, y, result, {n, z, c, v}, cyc);
      check("latency", cyc, NC);
      check("op_result", result, er);
      check("op_flags", {n, z, c, v}, ef);
      @(negedge clk);
      check("done_pulse_len", done, 0);
      check("held_result", result, er);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      int q[$];
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", {n, z, c, v}, 0);
      reset = 1'b0;
      chk_en = 1'b1;

      do_op(32'h00000005, 32'h00000003, 32'h00000002, 4'b0010, 1'b0);
      do_op(32'h12345678, 32'h12345678, 32'h00000000, 4'b0110, 1'b0);
      do_op(32'h00000100, 32'h00000001, 32'h000000FF, 4'b0010, 1'b1);
      do_op(32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 1'b0);
      do_op(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b1);
      do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1001, 1'b0);
      do_op(32'h00000005, 32'h00000003, 32'h00000002, 4'b0010, 1'b0);

      // Reset in the middle of an operation
      @(negedge clk);
      start = 1'b1; a = 32'h00000010; b = 32'h00000001;
      @(negedge clk);
      start = 1'b0;
      check("mid_run_old_result", result, 32'h00000002);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      $display("reset mid-run: busy=%0b done=%0b result=%08h NZCV=%04b", busy, done, result, {n, z, c, v});
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_flags", {n, z, c, v}, 0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("no_done_after_reset", pulses, 0);

      // Back-to-back with start held high
      @(negedge clk);
      start = 1'b1; a = 32'd20; b = 32'd7;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (done) q.push_back(k);
      end
      start = 1'b0;
      check("b2b_count", q.size(), 3);
      if (q.size() >= 3) begin
         $display("back-to-back done at cycles %0d %0d %0d", q[0], q[1], q[2]);
         check("b2b_first", q[0], NC);
         check("b2b_gap1", q[1] - q[0], 5);
         check("b2b_gap2", q[2] - q[1], 5);
      end
      repeat (8) @(negedge clk);
      check("idle_held_result", result, 32'h0000000D);
      check("idle_busy", busy, 0);

      // Single-chunk instance
      @(negedge clk);
      start2 = 1'b1; a2 = 32'h00000009; b2 = 32'h00000004;
      @(negedge clk);
      start2 = 1'b0;
      check("c32_busy", busy2, 1);
      check("c32_done_early", done2, 0);
      @(negedge clk);
      $display("chunk32 op 9 - 4 -> %08h done=%0b C=%0b", result2, done2, c2);
      check("c32_done", done2, 1);
      check("c32_result", result2, 32'h00000005);
      check("c32_flags", {n2, z2, c2, v2}, 4'b0010);
      @(negedge clk);
      check("c32_done_pulse", done2, 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
